// File: rtl/ntt_sdf_ctrl.sv
// ntt_sdf_ctrl: sequences jobs through an SDF NTT/INTT pipeline.
// It reads N coefficients from the input buffer and times the pipeline
// start pulse past the BRAM read latency. It then writes N results back
// when the pipeline signals finish. At most two jobs are in flight, and
// both must use the same mode.
//
// Feed FSM
//   state | meaning
//   IDLE  | no coefficients being read
//   FEED  | rd_en high, rd_addr stepping 0..N-1
// Writeback FSM
//   state | meaning
//   WIDLE | waiting for pipe_finish
//   WRITE | wr_en high, wr_addr stepping 1..N-1
//
// Writeback enters in the same cycle as pipe_finish, because pipe_finish
// coincides with the first output coefficient. For that reason wr_en and
// job_done are decoded from the live pipe_finish plus registered state.
// wr_addr comes straight from its counter register.
module ntt_sdf_ctrl #(
  parameter int LOGN       = 0,
  parameter int DELAY_BRAM = 0,
  localparam int AW        = (LOGN > 0) ? LOGN : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_intt,
  output logic          req_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          pipe_start,
  output logic          pipe_intt,
  input  logic          pipe_finish,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          job_done,
  output logic          busy,
  output logic          err
);

  localparam int            N    = 1 << LOGN;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam int            SRW  = (DELAY_BRAM > 0) ? DELAY_BRAM : 1;

  typedef enum logic {IDLE, FEED} feed_t;
  typedef enum logic {WIDLE, WRITE} wb_t;

  feed_t          feed_q, feed_d;
  wb_t            wb_q, wb_d;
  logic [AW-1:0]  rd_addr_d;
  logic [AW-1:0]  wcnt_d;
  logic [1:0]     inflight, inflight_d;
  logic [SRW-1:0] start_sr, start_sr_d;
  logic           start_d;
  logic           pending_d;
  logic           feed_last;
  logic           accept;
  logic           fin_take;
  logic           fin_bad;
  logic           rd_en_d;
  logic           busy_d;

  // Handshake and writeback strobes: the only outputs that are not flops.
  always_comb begin
    feed_last = (feed_q == FEED) && (rd_addr == LAST);
    req_ready = !rst && ((feed_q == IDLE) || feed_last) && (inflight < 2'd2) &&
                ((inflight == 2'd0) || (req_intt == pipe_intt));
    accept    = req_valid && req_ready;
    fin_take  = pipe_finish && (wb_q == WIDLE) && (inflight != 2'd0);
    fin_bad   = pipe_finish && ((wb_q == WRITE) || (inflight == 2'd0));
    wr_en     = (wb_q == WRITE) || fin_take;
    job_done  = wr_en && (wr_addr == LAST);
  end

  // Feed next state: an accept on the last feed cycle restarts at address 0 with no bubble.
  always_comb begin
    feed_d    = feed_q;
    rd_addr_d = rd_addr;
    if (accept) begin
      feed_d    = FEED;
      rd_addr_d = '0;
    end else if ((feed_q == FEED) && !feed_last) begin
      rd_addr_d = rd_addr + 1'b1;
    end else begin
      feed_d    = IDLE;
      rd_addr_d = '0;
    end
  end

  // Writeback next state: the cycle after the last write is already WIDLE, so a new finish can follow at once.
  always_comb begin
    wb_d   = wb_q;
    wcnt_d = wr_addr;
    if (wr_en) begin
      if (wr_addr == LAST) begin
        wb_d   = WIDLE;
        wcnt_d = '0;
      end else begin
        wb_d   = WRITE;
        wcnt_d = wr_addr + 1'b1;
      end
    end
  end

  // Bookkeeping and next values of the registered outputs.
  always_comb begin
    inflight_d = inflight;
    case ({accept, job_done})
      2'b10:   inflight_d = inflight + 2'd1;
      2'b01:   inflight_d = inflight - 2'd1;
      default: inflight_d = inflight;
    endcase
    // An accept now becomes the rd_addr=0 strobe next cycle; the shift register adds the BRAM latency.
    start_sr_d = SRW'({start_sr, accept});
    start_d    = (DELAY_BRAM == 0) ? accept : start_sr[SRW-1];
    pending_d  = (DELAY_BRAM == 0) ? 1'b0 : |start_sr_d;
    rd_en_d    = (feed_d == FEED);
    busy_d     = rd_en_d || (wb_d == WRITE) || (inflight_d != 2'd0) || pending_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      feed_q     <= IDLE;
      wb_q       <= WIDLE;
      rd_addr    <= '0;
      wr_addr    <= '0;
      inflight   <= 2'd0;
      start_sr   <= '0;
      rd_en      <= 1'b0;
      pipe_start <= 1'b0;
      pipe_intt  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      feed_q     <= feed_d;
      wb_q       <= wb_d;
      rd_addr    <= rd_addr_d;
      wr_addr    <= wcnt_d;
      inflight   <= inflight_d;
      start_sr   <= start_sr_d;
      rd_en      <= rd_en_d;
      pipe_start <= start_d;
      busy       <= busy_d;
      if (accept) pipe_intt <= req_intt;
      if (fin_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ntt_sdf_ctrl.sv
// Bench for ntt_sdf_ctrl with LOGN=4, DELAY_BRAM=2.
// The reference keeps per-cycle expectation rings of read and write windows.
// The rings are filled from accept and finish events using window arithmetic.
module tb_ntt_sdf_ctrl;

  localparam int LOGN = 4;
  localparam int N    = 16;
  localparam int D    = 2;
  localparam int MAXC = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_intt;
  logic            pipe_finish;
  logic            req_ready;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr;
  logic            pipe_start;
  logic            pipe_intt;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr;
  logic            job_done;
  logic            busy;
  logic            err;

  ntt_sdf_ctrl #(.LOGN(LOGN), .DELAY_BRAM(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_intt    (req_intt),
    .req_ready   (req_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .pipe_start  (pipe_start),
    .pipe_intt   (pipe_intt),
    .pipe_finish (pipe_finish),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .job_done    (job_done),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;

  bit e_rd_en   [MAXC];
  int e_rd_addr [MAXC];
  bit e_ps      [MAXC];
  bit e_wr_en   [MAXC];
  int e_wr_addr [MAXC];
  bit e_jd      [MAXC];
  int m_infl = 0;
  bit m_mode = 1'b0;
  bit m_err  = 1'b0;
  int last_acc = -1;
  int last_ps  = -1;
  int last_jd  = -1;

  task automatic expect_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, advance the reference, compare every output, update state.
  task automatic cycle(input bit v, input bit intt, input bit fin, input bit r);
    int  k;
    bit  rdy;
    bit  acc;
    bit  set_err;
    k       = cyc % MAXC;
    set_err = 1'b0;
    req_valid   = v;
    req_intt    = intt;
    pipe_finish = fin;
    rst         = r;
    if (fin && !r) begin
      if (m_infl == 0 || e_wr_en[k]) begin
        set_err = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          e_wr_en[(cyc + i) % MAXC]   = 1'b1;
          e_wr_addr[(cyc + i) % MAXC] = i;
        end
        e_jd[(cyc + N - 1) % MAXC] = 1'b1;
      end
    end
    rdy = !r && (!e_rd_en[k] || e_rd_addr[k] == N - 1) && (m_infl < 2) &&
          (m_infl == 0 || intt == m_mode);
    acc = v && rdy;

    @(negedge clk);
    expect_vec("req_ready", 32'(req_ready), 32'(rdy));
    expect_vec("rd_en", 32'(rd_en), 32'(e_rd_en[k]));
    if (e_rd_en[k]) expect_vec("rd_addr", 32'(rd_addr), e_rd_addr[k]);
    expect_vec("pipe_start", 32'(pipe_start), 32'(e_ps[k]));
    expect_vec("pipe_intt", 32'(pipe_intt), 32'(m_mode));
    expect_vec("wr_en", 32'(wr_en), 32'(e_wr_en[k]));
    if (e_wr_en[k]) expect_vec("wr_addr", 32'(wr_addr), e_wr_addr[k]);
    expect_vec("job_done", 32'(job_done), 32'(e_jd[k]));
    expect_vec("busy", 32'(busy), 32'(m_infl != 0));
    expect_vec("err", 32'(err), 32'(m_err));
    if (pipe_start === 1'b1) last_ps = cyc;
    if (job_done === 1'b1)   last_jd = cyc;

    if (r) begin
      for (int j = 0; j < MAXC; j++) begin
        e_rd_en[j] = 1'b0; e_ps[j] = 1'b0; e_wr_en[j] = 1'b0; e_jd[j] = 1'b0;
      end
      m_infl = 0;
      m_mode = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          e_rd_en[(cyc + 1 + i) % MAXC]   = 1'b1;
          e_rd_addr[(cyc + 1 + i) % MAXC] = i;
        end
        e_ps[(cyc + 1 + D) % MAXC] = 1'b1;
        m_mode   = intt;
        last_acc = cyc;
      end
      m_infl = m_infl + int'(acc) - int'(e_jd[k]);
      if (set_err) m_err = 1'b1;
      e_rd_en[k] = 1'b0; e_ps[k] = 1'b0; e_wr_en[k] = 1'b0; e_jd[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_intt = 1'b0; pipe_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Single NTT: accept at 0, finish at 40.
    base = cyc;
    for (int c = 0; c < 60; c++) cycle(c == 0, 0, c == 40, 0);
    expect_vec("single_ps_cycle", last_ps - base, 3);
    expect_vec("single_jd_cycle", last_jd - base, 55);

    // Two same-mode jobs back-to-back.
    cycle(0, 0, 0, 1);
    base = cyc;
    for (int c = 0; c < 76; c++) cycle(c == 0 || c == 16, 0, c == 40 || c == 56, 0);
    expect_vec("b2b_acc_cycle", last_acc - base, 16);
    expect_vec("b2b_ps_cycle", last_ps - base, 19);
    expect_vec("b2b_jd_cycle", last_jd - base, 71);

    // Mode change: INTT request held from cycle 2 until accepted.
    cycle(0, 0, 0, 1);
    base = cyc;
    for (int c = 0; c < 120; c++) cycle(c == 0 || (c >= 2 && c <= 56), c >= 2, c == 40 || c == 100, 0);
    expect_vec("mode_acc_cycle", last_acc - base, 56);

    // Third request blocked by two jobs in flight.
    cycle(0, 0, 0, 1);
    base = cyc;
    for (int c = 0; c < 100; c++) cycle(c == 0 || (c >= 16 && c <= 56), 0, c == 40 || c == 56 || c == 80, 0);
    expect_vec("third_acc_cycle", last_acc - base, 56);

    // Spurious finish with nothing in flight, then a finish mid-writeback at wr_addr=8.
    cycle(1, 0, 0, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    base = cyc;
    for (int c = 0; c < 60; c++) cycle(c == 0, 1, c == 40 || c == 48, 0);

    // Reset during feed at cycle 2.
    cycle(0, 0, 0, 1);
    base = cyc;
    for (int c = 0; c < 8; c++) cycle(c == 0, 0, 0, c == 2);

    // Randomised traffic.
    cycle(0, 0, 0, 1);
    for (int c = 0; c < 900; c++) begin
      bit v, m, f, r;
      int k;
      k = cyc % MAXC;
      v = ($urandom % 4) == 0;
      m = ($urandom % 3) == 0;
      if (m_infl > 0 && !e_wr_en[k]) f = ($urandom % 8) == 0;
      else                            f = ($urandom % 150) == 0;
      r = ($urandom % 300) == 0;
      cycle(v, m, f && !r, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
